// File: rtl/gated_integrator.sv
// Sliding-window integrator: running sum of the last n written samples over a 2^P_NBITS_ADDR circular buffer.
// Optional macro GATED_INTEGRATOR_ADDR_CLEAR_EN enables the addr_en synchronous clear / pointer load.
module gated_integrator #(
   parameter int P_NBITS_DATA_IN  = 14,
   parameter int P_NBITS_DATA_OUT = 20,
   parameter int P_NBITS_ADDR     = 6
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [P_NBITS_ADDR-1:0]     n,
   input  logic                        wr,
   input  logic [P_NBITS_DATA_IN-1:0]  d,
   input  logic                        addr_en,
   input  logic [P_NBITS_ADDR-1:0]     addr,
   output logic [P_NBITS_DATA_OUT-1:0] sum,
   output logic                        valid
);

   localparam int unsigned DEPTH = 2 ** P_NBITS_ADDR;

   if (P_NBITS_DATA_OUT < P_NBITS_DATA_IN + P_NBITS_ADDR) begin : g_width_chk
      $error("P_NBITS_DATA_OUT too narrow for a full window");
   end

   logic [P_NBITS_ADDR-1:0]     ptr;
   logic                        s1_vld;
   logic [P_NBITS_DATA_IN-1:0]  s1_d;
   logic [P_NBITS_ADDR-1:0]     s1_ptr;
   logic [P_NBITS_ADDR-1:0]     s1_n;
   logic [P_NBITS_DATA_IN-1:0]  mem [DEPTH];
   logic [P_NBITS_DATA_OUT-1:0] acc;
   logic                        s2_vld;
   logic [P_NBITS_ADDR-1:0]     old_idx;
   logic [P_NBITS_DATA_OUT-1:0] acc_next;

`ifndef GATED_INTEGRATOR_ADDR_CLEAR_EN
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr_en, addr};
`endif

   // n=0 wraps old_idx onto s1_ptr itself: the entry about to be overwritten is the oldest.
   always_comb begin
      old_idx  = s1_ptr - s1_n;
      acc_next = acc + P_NBITS_DATA_OUT'(s1_d) - P_NBITS_DATA_OUT'(mem[old_idx]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr    <= '0;
         s1_vld <= 1'b0;
         s1_d   <= '0;
         s1_ptr <= '0;
         s1_n   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         acc    <= '0;
         s2_vld <= 1'b0;
         sum    <= '0;
         valid  <= 1'b0;
      end else begin
`ifdef GATED_INTEGRATOR_ADDR_CLEAR_EN
         if (addr_en) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            acc    <= '0;
            ptr    <= addr;
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            valid  <= 1'b0;
         end else
`endif
         begin
            // Stage 1: capture sample, its slot and the window length in force at write time.
            s1_vld <= wr;
            if (wr) begin
               s1_d   <= d;
               s1_ptr <= ptr;
               s1_n   <= n;
               ptr    <= ptr + 1'b1;
            end
            // Stage 2: oldest entry is read in the same cycle it could be overwritten, so no forwarding is needed.
            s2_vld <= s1_vld;
            if (s1_vld) begin
               mem[s1_ptr] <= s1_d;
               acc         <= acc_next;
            end
            // Stage 3: registered output.
            valid <= s2_vld;
            if (s2_vld) sum <= acc;
         end
      end
   end

endmodule

// File: tb/tb_gated_integrator.sv
// Scoreboard bench for gated_integrator: a reference window model pushes expected sums, a negedge monitor pops them.
module tb_gated_integrator;

   localparam int DW = 14;
   localparam int OW = 20;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] n;
   logic          wr;
   logic [DW-1:0] d;
   logic          addr_en;
   logic [AW-1:0] addr;
   logic [OW-1:0] sum;
   logic          valid;

   always #5 clk = ~clk;

   gated_integrator #(
      .P_NBITS_DATA_IN (DW),
      .P_NBITS_DATA_OUT(OW),
      .P_NBITS_ADDR    (AW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .n      (n),
      .wr     (wr),
      .d      (d),
      .addr_en(addr_en),
      .addr   (addr),
      .sum    (sum),
      .valid  (valid)
   );

   int checks   = 0;
   int failures = 0;

   logic [OW-1:0] sbq[$];
   logic [OW-1:0] last_sum;
   logic [DW-1:0] mbuf[64];
   logic [AW-1:0] mptr;
   logic [OW-1:0] macc;
   bit            mon_en = 1'b0;

   // Monitor: every valid pops one expected sum; idle cycles must hold sum.
   always @(negedge clk) begin
      logic [OW-1:0] exp_s;
      if (rst === 1'b1 && mon_en) begin
         checks++;
         if (valid === 1'b1) begin
            if (sbq.size() == 0) begin
               failures++;
               $display("FAIL spurious_valid got sum=%0d, required no valid", sum);
               last_sum = sum;
            end else begin
               exp_s = sbq.pop_front();
               if (sum !== exp_s) begin
                  failures++;
                  $display("FAIL sum got=%0d required=%0d", sum, exp_s);
               end
               last_sum = exp_s;
            end
         end else if (valid !== 1'b0 || sum !== last_sum) begin
            failures++;
            $display("FAIL hold got valid=%b sum=%0d, required valid=0 sum=%0d", valid, sum, last_sum);
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 64; i++) mbuf[i] = '0;
      mptr     = '0;
      macc     = '0;
      last_sum = '0;
      sbq.delete();
   endtask

   // Drive one cycle; accepted writes update the reference window and queue the expected sum.
   task automatic drive(input logic w, input logic [DW-1:0] dv);
      logic [AW-1:0] idx;
      wr = w;
      d  = dv;
      if (w) begin
         idx        = mptr - n;
         macc       = macc + OW'(dv) - OW'(mbuf[idx]);
         mbuf[mptr] = dv;
         mptr       = mptr + 1'b1;
         sbq.push_back(macc);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      wr = 1'b0;
      for (int i = 0; i < 20 && sbq.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      mon_en = 1'b0;
      rst    = 1'b0;
      wr     = 1'b0;
      addr_en = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (sum !== '0 || valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got sum=%0d valid=%b, required 0/0", sum, valid);
      end
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic test_latency();
      n = 6'd16;
      drive(1'b1, 14'd3);
      wr = 1'b0;
      checks++;
      if (valid !== 1'b0) begin
         failures++;
         $display("FAIL latency_t0 got valid=%b required 0", valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (valid !== 1'b0) begin
         failures++;
         $display("FAIL latency_t1 got valid=%b required 0", valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (valid !== 1'b1 || sum !== 20'd3) begin
         failures++;
         $display("FAIL latency_t2 got valid=%b sum=%0d required 1/3", valid, sum);
      end
      drain();
   endtask

   task automatic test_steady();
      int m;
      apply_reset();
      n = 6'd16;
      for (int k = 1; k <= 40; k++) begin
         drive(1'b1, 14'd100);
         if (k >= 3) begin
            m = (k - 2 < 16) ? k - 2 : 16;
            checks++;
            if (valid !== 1'b1 || sum !== OW'(100 * m)) begin
               failures++;
               $display("FAIL steady k=%0d got valid=%b sum=%0d required 1/%0d", k, valid, sum, 100 * m);
            end
         end
      end
      drain();
      checks++;
      if (sum !== 20'd1600 || sbq.size() != 0) begin
         failures++;
         $display("FAIL steady_final got sum=%0d pending=%0d required 1600/0", sum, sbq.size());
      end
   endtask

   task automatic test_gaps();
      n = 6'd16;
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < 100; k++) drive(1'b1, DW'($urandom_range(0, 16383)));
         repeat ($urandom_range(1, 4)) drive(1'b0, '0);
      end
      drain();
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL gaps_pending got=%0d required 0", sbq.size());
      end
   endtask

   task automatic test_alternate();
      n = 6'd16;
      for (int k = 0; k < 100; k++) begin
         drive(1'b1, DW'($urandom_range(0, 16383)));
         drive(1'b0, '0);
      end
      drain();
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL alternate_pending got=%0d required 0", sbq.size());
      end
   endtask

   task automatic test_full_window();
      apply_reset();
      n = 6'd0;
      for (int k = 1; k <= 70; k++) begin
         drive(1'b1, 14'd16383);
         if (k >= 66) begin
            checks++;
            if (sum !== 20'd1048512) begin
               failures++;
               $display("FAIL full_window k=%0d got sum=%0d required 1048512", k, sum);
            end
         end
      end
      drain();
      checks++;
      if (sum !== 20'd1048512 || sbq.size() != 0) begin
         failures++;
         $display("FAIL full_window_final got sum=%0d pending=%0d required 1048512/0", sum, sbq.size());
      end
   endtask

   task automatic test_n_change();
      n = 6'd8;
      for (int k = 0; k < 20; k++) drive(1'b1, DW'($urandom_range(0, 1000)));
      n = 6'd3;
      for (int k = 0; k < 10; k++) drive(1'b1, DW'($urandom_range(0, 1000)));
      n = 6'd12;
      for (int k = 0; k < 10; k++) drive(1'b1, DW'($urandom_range(0, 1000)));
      drain();
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL n_change_pending got=%0d required 0", sbq.size());
      end
   endtask

   task automatic test_reset_midburst();
      n = 6'd16;
      for (int k = 0; k < 10; k++) drive(1'b1, 14'd50);
      mon_en = 1'b0;
      rst    = 1'b0;
      #1;
      checks++;
      if (sum !== '0 || valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_async got sum=%0d valid=%b required 0/0", sum, valid);
      end
      wr = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst    = 1'b1;
      mon_en = 1'b1;
      repeat (3) drive(1'b0, '0);
      drive(1'b1, 14'd5);
      drain();
      checks++;
      if (sum !== 20'd5 || sbq.size() != 0) begin
         failures++;
         $display("FAIL reset_resume got sum=%0d pending=%0d required 5/0", sum, sbq.size());
      end
   endtask

   task automatic test_addr_en();
      n = 6'd16;
`ifdef GATED_INTEGRATOR_ADDR_CLEAR_EN
      for (int k = 0; k < 20; k++) drive(1'b1, DW'($urandom_range(0, 16383)));
      drain();
      addr_en = 1'b1;
      addr    = 6'd10;
      wr      = 1'b1;
      d       = 14'd999;
      @(posedge clk);
      #1;
      addr_en = 1'b0;
      wr      = 1'b0;
      for (int i = 0; i < 64; i++) mbuf[i] = '0;
      macc = '0;
      mptr = 6'd10;
      drive(1'b1, 14'd7);
      drain();
      checks++;
      if (sum !== 20'd7) begin
         failures++;
         $display("FAIL addr_clear got sum=%0d required 7", sum);
      end
      for (int k = 0; k < 20; k++) drive(1'b1, DW'($urandom_range(0, 16383)));
`else
      for (int k = 0; k < 10; k++) drive(1'b1, DW'($urandom_range(0, 16383)));
      addr_en = 1'b1;
      addr    = 6'd10;
      drive(1'b1, DW'($urandom_range(0, 16383)));
      addr_en = 1'b0;
      for (int k = 0; k < 10; k++) drive(1'b1, DW'($urandom_range(0, 16383)));
`endif
      drain();
      checks++;
      if (sum !== macc || sbq.size() != 0) begin
         failures++;
         $display("FAIL addr_en_final got sum=%0d pending=%0d required %0d/0", sum, sbq.size(), macc);
      end
   endtask

   initial begin
      rst     = 1'b0;
      wr      = 1'b0;
      d       = '0;
      n       = 6'd16;
      addr_en = 1'b0;
      addr    = '0;
      model_reset();
      test_reset();
      test_latency();
      test_steady();
      test_gaps();
      test_alternate();
      test_full_window();
      test_n_change();
      test_reset_midburst();
      test_addr_en();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout got no completion, required finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/gated_integrator.md
GATED_INTEGRATOR -- requirements
Module: gated_integrator

Interface
REQ-001 SHALL have parameter P_NBITS_DATA_IN, default 14: input sample width (unsigned).
REQ-002 SHALL have parameter P_NBITS_DATA_OUT, default 20: sum width; SHALL be >= P_NBITS_DATA_IN + P_NBITS_ADDR.
REQ-003 SHALL have parameter P_NBITS_ADDR, default 6: window-length and pointer width; buffer depth 2^P_NBITS_ADDR (64).
REQ-004 SHALL have port clk, input, 1: sole clock, rising-edge active.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port n, input, P_NBITS_ADDR: integration window length in samples.
REQ-007 SHALL have port wr, input, 1: sample-write strobe, one sample per high cycle.
REQ-008 SHALL have port d, input, P_NBITS_DATA_IN: unsigned sample, sampled when wr=1.
REQ-009 SHALL have port addr_en, input, 1: clear/pointer-load strobe (see Configuration).
REQ-010 SHALL have port addr, input, P_NBITS_ADDR: write-pointer load value.
REQ-011 SHALL have port sum, output, P_NBITS_DATA_OUT: registered sum of the last n written samples.
REQ-012 SHALL have port valid, output, 1: registered one-cycle pulse marking a new sum.

Function
REQ-013 SHALL keep a circular buffer of 2^P_NBITS_ADDR samples and a write pointer that increments (wrapping 63->0) on each accepted write.
REQ-014 On a write, SHALL store d at the pointer and update running sum: sum_new = sum_old + d - buffer[ptr - n] (pointer arithmetic modulo depth, entry read before overwrite).
REQ-015 n=0 SHALL mean a window of 2^P_NBITS_ADDR samples (oldest entry = the one being overwritten).
REQ-016 Before n writes since reset/clear, unwritten entries SHALL read as zero, giving the partial sum.
REQ-017 Latency: sample captured at rising edge T SHALL produce its sum and valid=1 registered at edge T+2 (visible during cycle after T+2); three-stage pipeline (capture, read-oldest/compute, output).
REQ-018 valid SHALL be high exactly one cycle per accepted write; back-to-back writes produce back-to-back valid pulses.
REQ-019 With wr=0, no state SHALL change; sum SHALL hold its last value, valid=0.
REQ-020 Arithmetic SHALL be unsigned, no overflow possible at default widths (max 64 x 16383 = 1048512).
REQ-021 Changing n mid-stream SHALL take effect on the next write's oldest-sample lookup; running sum is not recomputed.

Reset
REQ-022 rst=0 SHALL asynchronously clear buffer, pointer, running sum, pipeline registers; sum=0, valid=0.
REQ-023 In-flight pipeline samples at reset assertion SHALL be discarded; no valid pulse follows.
REQ-024 Operation SHALL resume on the first rising edge after rst returns high.

Configuration
REQ-025 Macro GATED_INTEGRATOR_ADDR_CLEAR_EN: when defined, addr_en=1 at a rising edge SHALL synchronously zero buffer and running sum, load pointer with addr, ignore wr that cycle, and produce no valid.
REQ-026 When GATED_INTEGRATOR_ADDR_CLEAR_EN is undefined, addr_en and addr SHALL be ignored; ports remain present.

Verification
REQ-027 n=16, d=100 with wr continuously high -> valid every cycle, sums 100,200,...,1600, then 1600 steadily; first valid two edges after first capture.
REQ-028 n=16, 100-cycle bursts separated by 1-4 idle cycles -> no valid during gaps, sum held, window spans gaps (sums identical to gapless stream).
REQ-029 n=16, alternating wr 1/0 for 100 samples -> valid every other cycle, sums match gapless reference.
REQ-030 n=0, d=16383 for 70 writes -> sum saturates at 1048512 from write 64 on.
REQ-031 rst pulsed low mid-burst -> sum=0, valid=0 immediately; next write of d=5 gives sum=5.
REQ-032 With GATED_INTEGRATOR_ADDR_CLEAR_EN, addr_en pulse mid-stream with addr=10 -> running sum cleared; next write d=7 gives sum=7; without macro, stream unaffected.
